// File: rtl/vram_arb_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and constants for the video-RAM write-port arbiter.
//   arb_state_e : top-level sequencer state (ARB = serve requesters,
//                 CLEAR = fill frame buffer)
//   REQ_SPI/REQ_PAT : bit index of each requester in grant/select vectors
//   ADDR_W_DEF/DATA_W_DEF : default port widths
// -----------------------------------------------------------------------------
package vram_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } arb_state_e;

   localparam int REQ_SPI    = 0;  // SPI command handler
   localparam int REQ_PAT    = 1;  // pattern/overlay writer

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/vram_wr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req_i [1:0] : eligible (already masked) requests
//   ptr_i       : index of the requester granted most recently
//   sel_o [1:0] : one-hot select of the winner, zero when nothing is eligible
// On a tie the requester that did not win last time is chosen.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = 2'b00;
      unique case (req_i)
         2'b01:   sel_o = 2'b01;
         2'b10:   sel_o = 2'b10;
         2'b11:   sel_o = ptr_i ? 2'b01 : 2'b10;
         default: sel_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/vram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// vram_wr_arbiter
// Shares the single VRAM write port between the SPI command handler (req0)
// and the pattern/overlay writer (req1), round-robin on ties. A clear
// sequencer fills addresses 0..CLEAR_DEPTH-1 with CLEAR_VALUE and locks out
// both requesters while it runs. All outputs are registered.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   req0/addr0/data0 -> gnt0      : requester 0 (hold until gnt0)
//   req1/addr1/data1 -> gnt1      : requester 1 (hold until gnt1)
//   clear_start -> clear_busy     : single-cycle clear command / busy flag
//   mem_addr/mem_data/mem_we      : RAM write port
// Optional build macro VRAM_WR_ARBITER_STATS_EN adds gnt_cnt0/gnt_cnt1,
// saturating 16-bit grant counters zeroed by reset and by an accepted clear.
// -----------------------------------------------------------------------------
module vram_wr_arbiter
   import vram_arb_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                CLEAR_DEPTH = 1024,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt1,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we
`ifdef VRAM_WR_ARBITER_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   localparam int CW = (CLEAR_DEPTH > 1) ? $clog2(CLEAR_DEPTH) : 1;
   localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_DEPTH - 1);

   if (64'(CLEAR_DEPTH) > (64'd1 << ADDR_W)) begin : g_depth_chk
      $error("vram_wr_arbiter: CLEAR_DEPTH exceeds address space");
   end

   arb_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ptr_q, ptr_d;      // last granted requester
   logic [1:0]        gnt_q, gnt_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [1:0] elig, sel;
   logic       clr_acc, arb_go;

   // A requester granted this cycle is masked so a held req is not
   // granted twice back to back.
   assign elig = {req1 & ~gnt_q[REQ_PAT], req0 & ~gnt_q[REQ_SPI]};

   rr_arb2 u_rr (
      .req_i (elig),
      .ptr_i (ptr_q),
      .sel_o (sel)
   );

   assign clr_acc = (state_q == ARB) && clear_start;
   // Arbitration also runs in the final clear cycle so the first cycle
   // after clear_busy falls can already carry a grant.
   assign arb_go  = ((state_q == ARB) && !clear_start) ||
                    ((state_q == CLEAR) && (cnt_q == CLR_LAST));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = 2'b00;
      we_d    = 1'b0;
      busy_d  = busy_q;
      addr_d  = addr_q;
      data_d  = data_q;

      if (clr_acc) begin
         state_d = CLEAR;
         busy_d  = 1'b1;
         cnt_d   = '0;
         we_d    = 1'b1;
         addr_d  = '0;
         data_d  = CLEAR_VALUE;
      end else if (state_q == CLEAR) begin
         if (cnt_q == CLR_LAST) begin
            state_d = ARB;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end else begin
            cnt_d  = cnt_q + CW'(1);
            we_d   = 1'b1;
            addr_d = ADDR_W'(cnt_d);
            data_d = CLEAR_VALUE;
         end
      end

      if (arb_go && (sel != 2'b00)) begin
         gnt_d  = sel;
         we_d   = 1'b1;
         ptr_d  = sel[REQ_PAT];
         addr_d = sel[REQ_PAT] ? addr1 : addr0;
         data_d = sel[REQ_PAT] ? data1 : data0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
         cnt_q   <= '0;
         ptr_q   <= 1'b1;
         gnt_q   <= 2'b00;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign gnt0       = gnt_q[REQ_SPI];
   assign gnt1       = gnt_q[REQ_PAT];
   assign mem_we     = we_q;
   assign clear_busy = busy_q;
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;

`ifdef VRAM_WR_ARBITER_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (clr_acc) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt_d[REQ_SPI] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
         if (gnt_d[REQ_PAT] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif

endmodule
